// File: rtl/uart_tx_pkg.sv
// Shared UART constants and FSM state encoding for the transmit and receive paths.
package uart_tx_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF     = 9600;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned FRAME_BITS   = 10;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned BIT_IDX_W    = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_bps_tx.sv
// Bit-timing generator: counts BIT_CYC cycles per bit while run is high.
module uart_bps_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BIT_CYC = CLK_FREQ_DEF / BAUD_DEF
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             run,
  output logic             bit_end,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             end_d, end_q;

  // Counter clears while idle and at every bit boundary; bit_end flags the last cycle of a bit.
  always_comb begin
    cnt_d = '0;
    if (run && !end_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    end_d = run && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt_q <= '0;
      end_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      end_q <= end_d;
    end
  end

  assign bit_end = end_q;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer for back-to-back frames.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF,
  parameter int unsigned BIT_CYC  = CLK_FREQ / BAUD
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 pi_flag,
  input  logic [DATA_BITS-1:0] pi_data,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIT_CYC - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e          state_d, state_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] buf_d, buf_q;
  logic                 buf_full_d, buf_full_q;
  logic [BIT_IDX_W-1:0] idx_d, idx_q;
  logic                 tx_d, tx_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 ready_d, ready_q;
  logic                 bit_end;
  logic [CNT_W-1:0]     bit_cnt;

  uart_bps_tx #(.BIT_CYC(BIT_CYC)) u_bps (
    .sclk    (sclk),
    .rst     (rst),
    .run     (state_q != IDLE),
    .bit_end (bit_end),
    .bit_cnt (bit_cnt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        if (pi_flag) begin
          shift_d = pi_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + BIT_IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        // Chain the next frame with no idle gap if one is waiting or arriving now.
        if (bit_end) begin
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            state_d    = START;
          end else if (pi_flag) begin
            shift_d = pi_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !buf_full_q && pi_flag && !((state_q == STOP) && bit_end)) begin
      buf_d      = pi_data;
      buf_full_d = 1'b1;
    end

    // Line outputs are registered images of the current state.
    tx_d = 1'b1;
    if (state_q == START) tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == STOP) && (bit_cnt == LAST_CNT);
    ready_d = !buf_full_d;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      idx_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign pi_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed timing checks plus random strobes against a frame-level model.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int unsigned BC        = 16;
  localparam int          FRAME_CYC = int'(FRAME_BITS * BC);

  logic       sclk = 1'b0;
  logic       rst;
  logic       pi_flag;
  logic [7:0] pi_data;
  logic       pi_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int cyc      = 0;
  int done_cnt = 0;
  int vecs     = 0;
  int fails    = 0;

  // Model: f_st is the edge at which the latest (or current) frame was launched.
  int   f_st  = -100000;
  bit   buf_v = 1'b0;
  int   exp_b[$];
  int   exp_s[$];
  logic [9:0] mon_f[$];
  int   mon_s[$];

  uart_tx #(.BIT_CYC(BC)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .pi_flag  (pi_flag),
    .pi_data  (pi_data),
    .pi_ready (pi_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;
  always @(posedge sclk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Line monitor: decodes frames by sampling mid-bit; a dropped busy aborts the frame.
  initial begin : mon
    int         ph;
    int         st;
    bit         act;
    logic [9:0] fr;
    ph = 0; st = 0; act = 1'b0; fr = '0;
    forever begin
      @(posedge sclk); #1;
      if (act && tx_busy !== 1'b1) act = 1'b0;
      else if (act) ph++;
      else if (tx === 1'b0) begin
        act = 1'b1; ph = 0; st = cyc;
      end
      if (act && (ph % int'(BC)) == int'(BC / 2)) fr[4'(ph / int'(BC))] = tx;
      if (act && ph == FRAME_CYC - 1) begin
        act = 1'b0;
        mon_f.push_back(fr);
        mon_s.push_back(st);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge sclk); #1;
    end
  endtask

  task automatic retire(input int e);
    while (buf_v && (f_st + FRAME_CYC < e)) begin
      f_st += FRAME_CYC;
      buf_v = 1'b0;
    end
  endtask

  task automatic model_accept(input int e, input logic [7:0] b);
    retire(e);
    if (e > f_st && e < f_st + FRAME_CYC) begin
      if (!buf_v) begin
        buf_v = 1'b1;
        exp_b.push_back(int'(b));
        exp_s.push_back(f_st + FRAME_CYC + 1);
      end
    end else if (e == f_st + FRAME_CYC) begin
      if (!buf_v) begin
        f_st = e;
        exp_b.push_back(int'(b));
        exp_s.push_back(e + 1);
      end
    end else begin
      f_st = e;
      exp_b.push_back(int'(b));
      exp_s.push_back(e + 1);
    end
  endtask

  // Present one strobe sampled at the next edge; afterwards we sit just past that edge.
  task automatic strobe(input logic [7:0] b);
    int e;
    e = cyc + 1;
    retire(e);
    chk("pi_ready_before_strobe", 32'(pi_ready), 32'(!buf_v));
    pi_flag = 1'b1;
    pi_data = b;
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    model_accept(e, b);
  endtask

  initial begin
    int         n;
    logic [7:0] v;
    logic [7:0] lb [3];
    logic [9:0] fr;
    int         nf;
    int         e;

    rst = 1'b1; pi_flag = 1'b0; pi_data = '0;
    repeat (3) begin @(posedge sclk); #1; end
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_busy", 32'(tx_busy), 32'(0));
    chk("reset_done", 32'(tx_done), 32'(0));
    chk("reset_ready", 32'(pi_ready), 32'(1));
    rst = 1'b0;
    wait_to(cyc + 5);

    // Single byte A5 with exact cycle positions.
    v = 8'hA5;
    n = cyc + 1;
    strobe(v);
    wait_to(n + 1);
    chk("a5_start_first", 32'(tx), 32'(0));
    chk("a5_busy_rise", 32'(tx_busy), 32'(1));
    wait_to(n + 16);
    chk("a5_start_last", 32'(tx), 32'(0));
    for (int k = 0; k < 8; k++) begin
      wait_to(n + 17 + 16 * k + 8);
      chk("a5_data_bit", 32'(tx), 32'(v[k]));
    end
    wait_to(n + 152);
    chk("a5_stop", 32'(tx), 32'(1));
    wait_to(n + 159);
    chk("a5_done_early", 32'(tx_done), 32'(0));
    wait_to(n + 160);
    chk("a5_done", 32'(tx_done), 32'(1));
    chk("a5_busy_in_stop", 32'(tx_busy), 32'(1));
    wait_to(n + 161);
    chk("a5_done_fall", 32'(tx_done), 32'(0));
    chk("a5_busy_fall", 32'(tx_busy), 32'(0));
    chk("a5_idle_tx", 32'(tx), 32'(1));

    // Back-to-back 55 then 0F, with an FF overrun while the buffer is full.
    wait_to(cyc + 10);
    n = cyc + 1;
    strobe(8'h55);
    wait_to(n + 19);
    strobe(8'h0F);
    chk("b2b_ready_low", 32'(pi_ready), 32'(0));
    wait_to(n + 39);
    strobe(8'hFF);
    chk("overrun_ready_low", 32'(pi_ready), 32'(0));
    wait_to(n + 159);
    chk("b2b_ready_still_low", 32'(pi_ready), 32'(0));
    wait_to(n + 160);
    chk("b2b_ready_unload", 32'(pi_ready), 32'(1));
    chk("b2b_done1", 32'(tx_done), 32'(1));
    wait_to(n + 161);
    chk("b2b_no_gap", 32'(tx), 32'(0));
    chk("b2b_busy_held", 32'(tx_busy), 32'(1));
    wait_to(n + 320);
    chk("b2b_done2", 32'(tx_done), 32'(1));
    wait_to(n + 321);
    chk("b2b_busy_fall", 32'(tx_busy), 32'(0));

    // Strobe landing in the final stop cycle goes out immediately.
    wait_to(cyc + 10);
    n = cyc + 1;
    strobe(8'($urandom_range(0, 255)));
    wait_to(n + 159);
    strobe(8'($urandom_range(0, 255)));
    chk("edge_done", 32'(tx_done), 32'(1));
    wait_to(n + 161);
    chk("edge_no_gap", 32'(tx), 32'(0));
    chk("edge_busy", 32'(tx_busy), 32'(1));
    wait_to(n + 330);

    // Reset during data bit 3 with a byte buffered; rst also beats a same-cycle strobe.
    n = cyc + 1;
    strobe(8'h96);
    wait_to(n + 29);
    strobe(8'h77);
    wait_to(n + 70);
    rst = 1'b1; pi_flag = 1'b1; pi_data = 8'hE7;
    @(posedge sclk); #1;
    rst = 1'b0; pi_flag = 1'b0;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_ready", 32'(pi_ready), 32'(1));
    chk("rst_done", 32'(tx_done), 32'(0));
    void'(exp_b.pop_back()); void'(exp_b.pop_back());
    void'(exp_s.pop_back()); void'(exp_s.pop_back());
    f_st = -100000; buf_v = 1'b0;
    wait_to(cyc + 5);
    chk("rst_priority_busy", 32'(tx_busy), 32'(0));
    chk("rst_priority_tx", 32'(tx), 32'(1));
    n = cyc + 1;
    strobe(8'h3C);
    wait_to(n + 170);

    // Extreme patterns, then random strobes with deliberate frame-boundary hits.
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      wait_to(cyc + 2);
      strobe(lb[i]);
    end
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0 && f_st + FRAME_CYC > cyc) e = f_st + FRAME_CYC;
      else e = cyc + int'($urandom_range(1, 340));
      wait_to(e - 1);
      strobe(8'($urandom_range(0, 255)));
    end
    wait_to(f_st + 2 * FRAME_CYC + 10);

    // Scoreboard: decoded line contents against the model.
    chk("frame_count", 32'(mon_f.size()), 32'(exp_b.size()));
    chk("done_count", 32'(done_cnt), 32'(exp_b.size()));
    nf = (mon_f.size() < exp_b.size()) ? mon_f.size() : exp_b.size();
    for (int i = 0; i < nf; i++) begin
      fr = mon_f[i];
      chk("frame_data", 32'(fr[8:1]), 32'(exp_b[i]));
      chk("frame_start_bit", 32'(fr[0]), 32'(0));
      chk("frame_stop_bit", 32'(fr[9]), 32'(1));
      chk("frame_start_cycle", 32'(mon_s[i]), 32'(exp_s[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
